layer_inter_pingpong_ctrl: RTL and testbench

LAYER_INTER_PINGPONG_CTRL -- requirements
Module: layer_inter_pingpong_ctrl

---
 rtl/layer_inter_pkg.sv | 31 +++
 rtl/layer_bank_mux.sv | 57 +++++
 rtl/layer_inter_pingpong_ctrl.sv | 177 +++++++++++++++++
 tb/tb_layer_inter_pingpong_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_inter_pkg.sv
// Shared types for the inter-layer ping-pong buffer controller.
package layer_inter_pkg;

    // Ownership state of one inter-layer feature buffer
    typedef enum logic [1:0] {
        FREE  = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2,
        DRAIN = 2'd3
    } bank_state_t;

    // Producer (former layer) pass sequencer
    typedef enum logic [1:0] {
        F_IDLE  = 2'd0,
        F_START = 2'd1,
        F_RUN   = 2'd2
    } prod_state_t;

    // Consumer (next layer) pass sequencer
    typedef enum logic [1:0] {
        N_IDLE  = 2'd0,
        N_START = 2'd1,
        N_RUN   = 2'd2
    } cons_state_t;

    // Bank pointer width; a single bank still needs one bit of pointer
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/layer_bank_mux.sv
// Routes the owning layer's port-A/B address and strobes onto one bank.
module layer_bank_mux
    import layer_inter_pkg::*;
#(
    parameter int ADDR_WIDTH = 9
) (
    input  logic [1:0]            bank_state,
    input  logic [ADDR_WIDTH-1:0] address_a_former,
    input  logic [ADDR_WIDTH-1:0] address_b_former,
    input  logic                  rden_a_former,
    input  logic                  rden_b_former,
    input  logic                  wren_a_former,
    input  logic                  wren_b_former,
    input  logic [ADDR_WIDTH-1:0] address_a_next,
    input  logic [ADDR_WIDTH-1:0] address_b_next,
    input  logic                  rden_a_next,
    input  logic                  rden_b_next,
    input  logic                  wren_a_next,
    input  logic                  wren_b_next,
    output logic [ADDR_WIDTH-1:0] addr_a,
    output logic [ADDR_WIDTH-1:0] addr_b,
    output logic                  rden_a,
    output logic                  rden_b,
    output logic                  wren_a,
    output logic                  wren_b
);

    // Filling bank belongs to the producer, draining bank to the consumer; idle banks are parked
    always_comb begin
        addr_a = '0;
        addr_b = '0;
        rden_a = 1'b0;
        rden_b = 1'b0;
        wren_a = 1'b0;
        wren_b = 1'b0;
        case (bank_state_t'(bank_state))
            FILL: begin
                addr_a = address_a_former;
                addr_b = address_b_former;
                rden_a = rden_a_former;
                rden_b = rden_b_former;
                wren_a = wren_a_former;
                wren_b = wren_b_former;
            end
            DRAIN: begin
                addr_a = address_a_next;
                addr_b = address_b_next;
                rden_a = rden_a_next;
                rden_b = rden_b_next;
                wren_a = wren_a_next;
                wren_b = wren_b_next;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/layer_inter_pingpong_ctrl.sv
// Ping-pong controller handing inter-layer feature buffers from producer to consumer.
module layer_inter_pingpong_ctrl
    import layer_inter_pkg::*;
#(
    parameter int NUM_BANKS  = 2,
    parameter int ADDR_WIDTH = 9,
    parameter int Q_WIDTH    = 400
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            enable,
    output logic                            layer_former_enable,
    output logic                            layer_former_reset,
    input  logic                            layer_former_done,
    output logic                            layer_next_enable,
    output logic                            layer_next_reset,
    input  logic                            layer_next_done,
    input  logic [ADDR_WIDTH-1:0]           address_a_former,
    input  logic [ADDR_WIDTH-1:0]           address_b_former,
    input  logic                            rden_a_former,
    input  logic                            rden_b_former,
    input  logic                            wren_a_former,
    input  logic                            wren_b_former,
    input  logic [ADDR_WIDTH-1:0]           address_a_next,
    input  logic [ADDR_WIDTH-1:0]           address_b_next,
    input  logic                            rden_a_next,
    input  logic                            rden_b_next,
    input  logic                            wren_a_next,
    input  logic                            wren_b_next,
    output logic [NUM_BANKS*ADDR_WIDTH-1:0] bank_addr_a,
    output logic [NUM_BANKS*ADDR_WIDTH-1:0] bank_addr_b,
    output logic [NUM_BANKS-1:0]            bank_rden_a,
    output logic [NUM_BANKS-1:0]            bank_rden_b,
    output logic [NUM_BANKS-1:0]            bank_wren_a,
    output logic [NUM_BANKS-1:0]            bank_wren_b,
    input  logic [NUM_BANKS*Q_WIDTH-1:0]    bank_q_a_all,
    input  logic [NUM_BANKS*Q_WIDTH-1:0]    bank_q_b_all,
    output logic [Q_WIDTH-1:0]              q_a_next,
    output logic [Q_WIDTH-1:0]              q_b_next,
    output logic [15:0]                     frames_done,
    output logic                            busy,
    output logic                            err
);

    localparam int PW = ptr_width(NUM_BANKS);
    localparam logic [PW-1:0] LAST_PTR = PW'(NUM_BANKS - 1);

    bank_state_t   bank_st [NUM_BANKS];
    prod_state_t   f_state;
    cons_state_t   n_state;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Both sequencers share one block so that a producer and consumer done in the same
    // cycle update their (necessarily different-state) banks together; the transitions
    // each side makes need disjoint source states, so no bank is written twice per edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_BANKS; i++) begin
                bank_st[i] <= FREE;
            end
            f_state             <= F_IDLE;
            n_state             <= N_IDLE;
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            layer_former_enable <= 1'b0;
            layer_former_reset  <= 1'b0;
            layer_next_enable   <= 1'b0;
            layer_next_reset    <= 1'b0;
            frames_done         <= '0;
            err                 <= 1'b0;
        end else begin
            case (f_state)
                F_IDLE: begin
                    if (enable && bank_st[wr_ptr] == FREE) begin
                        bank_st[wr_ptr]    <= FILL;
                        f_state            <= F_START;
                        layer_former_reset <= 1'b1;
                    end
                end
                F_START: begin
                    f_state             <= F_RUN;
                    layer_former_reset  <= 1'b0;
                    layer_former_enable <= 1'b1;
                end
                F_RUN: begin
                    if (layer_former_done) begin
                        bank_st[wr_ptr]     <= FULL;
                        wr_ptr              <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
                        f_state             <= F_IDLE;
                        layer_former_enable <= 1'b0;
                    end
                end
                default: f_state <= F_IDLE;
            endcase

            case (n_state)
                N_IDLE: begin
                    if (bank_st[rd_ptr] == FULL) begin
                        bank_st[rd_ptr]  <= DRAIN;
                        n_state          <= N_START;
                        layer_next_reset <= 1'b1;
                    end
                end
                N_START: begin
                    n_state           <= N_RUN;
                    layer_next_reset  <= 1'b0;
                    layer_next_enable <= 1'b1;
                end
                N_RUN: begin
                    if (layer_next_done) begin
                        bank_st[rd_ptr]   <= FREE;
                        rd_ptr            <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
                        n_state           <= N_IDLE;
                        layer_next_enable <= 1'b0;
                        frames_done       <= frames_done + 16'd1;
                    end
                end
                default: n_state <= N_IDLE;
            endcase

            if ((layer_former_done && f_state != F_RUN) ||
                (layer_next_done && n_state != N_RUN)) begin
                err <= 1'b1;
            end
        end
    end

    // Activity flag: any sequencer mid-pass or any bank still holding data
    always_comb begin
        busy = (f_state != F_IDLE) || (n_state != N_IDLE);
        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            if (bank_st[i] != FREE) begin
                busy = 1'b1;
            end
        end
    end

    // Consumer read data comes from the bank the read pointer designates
    always_comb begin
        q_a_next = '0;
        q_b_next = '0;
        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            if (rd_ptr == PW'(i)) begin
                q_a_next = bank_q_a_all[i*Q_WIDTH +: Q_WIDTH];
                q_b_next = bank_q_b_all[i*Q_WIDTH +: Q_WIDTH];
            end
        end
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        layer_bank_mux #(
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_mux (
            .bank_state       (bank_st[g]),
            .address_a_former (address_a_former),
            .address_b_former (address_b_former),
            .rden_a_former    (rden_a_former),
            .rden_b_former    (rden_b_former),
            .wren_a_former    (wren_a_former),
            .wren_b_former    (wren_b_former),
            .address_a_next   (address_a_next),
            .address_b_next   (address_b_next),
            .rden_a_next      (rden_a_next),
            .rden_b_next      (rden_b_next),
            .wren_a_next      (wren_a_next),
            .wren_b_next      (wren_b_next),
            .addr_a           (bank_addr_a[g*ADDR_WIDTH +: ADDR_WIDTH]),
            .addr_b           (bank_addr_b[g*ADDR_WIDTH +: ADDR_WIDTH]),
            .rden_a           (bank_rden_a[g]),
            .rden_b           (bank_rden_b[g]),
            .wren_a           (bank_wren_a[g]),
            .wren_b           (bank_wren_b[g])
        );
    end

endmodule

// File: tb/tb_layer_inter_pingpong_ctrl.sv
// Directed bench: two-bank ping-pong instance plus a single-bank serialized instance.
module tb_layer_inter_pingpong_ctrl;

    localparam int AW = 9;
    localparam int QW = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b0;
    logic layer_former_done = 1'b0;
    logic layer_next_done = 1'b0;
    logic [AW-1:0] address_a_former, address_b_former, address_a_next, address_b_next;
    logic rden_a_former, rden_b_former, wren_a_former, wren_b_former;
    logic rden_a_next, rden_b_next, wren_a_next, wren_b_next;

    // two-bank instance
    logic          former_en0, former_rst0, next_en0, next_rst0, busy0, err0;
    logic [2*AW-1:0] bank_addr_a0, bank_addr_b0;
    logic [1:0]    bank_rden_a0, bank_rden_b0, bank_wren_a0, bank_wren_b0;
    logic [2*QW-1:0] bank_q_a0 = 32'hBBBB_AAAA;
    logic [2*QW-1:0] bank_q_b0 = 32'h2222_1111;
    logic [QW-1:0] q_a0, q_b0;
    logic [15:0]   frames0;

    // single-bank instance
    logic          former_en1, former_rst1, next_en1, next_rst1, busy1, err1;
    logic [AW-1:0] bank_addr_a1, bank_addr_b1;
    logic [0:0]    bank_rden_a1, bank_rden_b1, bank_wren_a1, bank_wren_b1;
    logic [QW-1:0] bank_q_a1 = 16'h5555;
    logic [QW-1:0] bank_q_b1 = 16'h6666;
    logic [QW-1:0] q_a1, q_b1;
    logic [15:0]   frames1;

    int n_cmp = 0;
    int n_bad = 0;
    int overlap_cnt = 0;
    int drain_wr_cnt = 0;
    bit mon_on = 1'b0;
    bit ok;

    always #5 clock = ~clock;

    layer_inter_pingpong_ctrl #(
        .NUM_BANKS (2),
        .ADDR_WIDTH(AW),
        .Q_WIDTH   (QW)
    ) dut0 (
        .clock(clock), .reset(reset), .enable(enable),
        .layer_former_enable(former_en0), .layer_former_reset(former_rst0),
        .layer_former_done(layer_former_done),
        .layer_next_enable(next_en0), .layer_next_reset(next_rst0),
        .layer_next_done(layer_next_done),
        .address_a_former(address_a_former), .address_b_former(address_b_former),
        .rden_a_former(rden_a_former), .rden_b_former(rden_b_former),
        .wren_a_former(wren_a_former), .wren_b_former(wren_b_former),
        .address_a_next(address_a_next), .address_b_next(address_b_next),
        .rden_a_next(rden_a_next), .rden_b_next(rden_b_next),
        .wren_a_next(wren_a_next), .wren_b_next(wren_b_next),
        .bank_addr_a(bank_addr_a0), .bank_addr_b(bank_addr_b0),
        .bank_rden_a(bank_rden_a0), .bank_rden_b(bank_rden_b0),
        .bank_wren_a(bank_wren_a0), .bank_wren_b(bank_wren_b0),
        .bank_q_a_all(bank_q_a0), .bank_q_b_all(bank_q_b0),
        .q_a_next(q_a0), .q_b_next(q_b0),
        .frames_done(frames0), .busy(busy0), .err(err0)
    );

    layer_inter_pingpong_ctrl #(
        .NUM_BANKS (1),
        .ADDR_WIDTH(AW),
        .Q_WIDTH   (QW)
    ) dut1 (
        .clock(clock), .reset(reset), .enable(enable),
        .layer_former_enable(former_en1), .layer_former_reset(former_rst1),
        .layer_former_done(layer_former_done),
        .layer_next_enable(next_en1), .layer_next_reset(next_rst1),
        .layer_next_done(layer_next_done),
        .address_a_former(address_a_former), .address_b_former(address_b_former),
        .rden_a_former(rden_a_former), .rden_b_former(rden_b_former),
        .wren_a_former(wren_a_former), .wren_b_former(wren_b_former),
        .address_a_next(address_a_next), .address_b_next(address_b_next),
        .rden_a_next(rden_a_next), .rden_b_next(rden_b_next),
        .wren_a_next(wren_a_next), .wren_b_next(wren_b_next),
        .bank_addr_a(bank_addr_a1), .bank_addr_b(bank_addr_b1),
        .bank_rden_a(bank_rden_a1), .bank_rden_b(bank_rden_b1),
        .bank_wren_a(bank_wren_a1), .bank_wren_b(bank_wren_b1),
        .bank_q_a_all(bank_q_a1), .bank_q_b_all(bank_q_b1),
        .q_a_next(q_a1), .q_b_next(q_b1),
        .frames_done(frames1), .busy(busy1), .err(err1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // bounded wait for an enable on the single-bank instance
    task automatic wait_en1(input bit consumer, output bit found);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            step();
            if (consumer ? next_en1 : former_en1) found = 1'b1;
        end
    endtask

    // serialized-mode invariants watched continuously while enabled
    always @(negedge clock) begin
        if (mon_on) begin
            if (former_en1 && next_en1) overlap_cnt++;
            if ((next_en1 || next_rst1) && (bank_wren_a1 != 1'b0 || bank_wren_b1 != 1'b0))
                drain_wr_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        address_a_former = 9'h0A5; address_b_former = 9'h05A;
        address_a_next   = 9'h133; address_b_next   = 9'h0CC;
        rden_a_former = 1'b1; rden_b_former = 1'b0; wren_a_former = 1'b1; wren_b_former = 1'b1;
        rden_a_next   = 1'b1; rden_b_next   = 1'b1; wren_a_next   = 1'b0; wren_b_next   = 1'b0;

        // reset state
        step(); step();
        check_eq("rst_former_en",  former_en0, 0);
        check_eq("rst_former_rst", former_rst0, 0);
        check_eq("rst_next_en",    next_en0, 0);
        check_eq("rst_next_rst",   next_rst0, 0);
        check_eq("rst_addr_a",     bank_addr_a0, 0);
        check_eq("rst_wren_a",     bank_wren_a0, 0);
        check_eq("rst_rden_a",     bank_rden_a0, 0);
        check_eq("rst_busy",       busy0, 0);
        check_eq("rst_frames",     frames0, 0);
        check_eq("rst_err",        err0, 0);

        // first producer pass on bank 0
        reset = 1'b1; enable = 1'b1;
        step();
        check_eq("p0_start_pulse", former_rst0, 1);
        check_eq("p0_start_en",    former_en0, 0);
        check_eq("p0_busy",        busy0, 1);
        check_eq("p0_fill_addr_a", bank_addr_a0, {9'h000, 9'h0A5});
        check_eq("p0_fill_wren_a", bank_wren_a0, 2'b01);
        check_eq("p0_fill_rden_b", bank_rden_b0, 2'b00);
        step();
        check_eq("p0_run_rst", former_rst0, 0);
        check_eq("p0_run_en",  former_en0, 1);
        step();
        layer_former_done = 1'b1;
        step();
        layer_former_done = 1'b0;
        check_eq("k_former_en",  former_en0, 0);
        check_eq("k_next_rst",   next_rst0, 0);
        check_eq("k_full_addr",  bank_addr_a0, 0);
        check_eq("k_q_a_bank0",  q_a0, 16'hAAAA);
        step();
        check_eq("k1_next_rst",   next_rst0, 1);
        check_eq("k1_former_rst", former_rst0, 1);
        check_eq("k1_next_en",    next_en0, 0);
        step();
        check_eq("k2_next_en",    next_en0, 1);
        check_eq("k2_former_en",  former_en0, 1);
        check_eq("k2_next_rst",   next_rst0, 0);
        check_eq("k2_addr_a",     bank_addr_a0, {9'h0A5, 9'h133});
        check_eq("k2_wren_a",     bank_wren_a0, 2'b10);
        check_eq("k2_rden_b",     bank_rden_b0, 2'b01);

        // simultaneous done: consumer on bank 0, producer on bank 1
        layer_former_done = 1'b1; layer_next_done = 1'b1;
        step();
        layer_former_done = 1'b0; layer_next_done = 1'b0;
        check_eq("both_frames",  frames0, 1);
        check_eq("both_err",     err0, 0);
        check_eq("both_fen",     former_en0, 0);
        check_eq("both_nen",     next_en0, 0);
        check_eq("both_q_a",     q_a0, 16'hBBBB);
        check_eq("both_q_b",     q_b0, 16'h2222);
        check_eq("both_addr_a",  bank_addr_a0, 0);
        step();
        check_eq("both_next_rst1",   next_rst0, 1);
        check_eq("both_former_rst0", former_rst0, 1);
        step();

        // consumer stalled on bank 1, producer finishes bank 0 and must then wait
        layer_former_done = 1'b1;
        step();
        layer_former_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("stall_former_en",  former_en0, 0);
            check_eq("stall_former_rst", former_rst0, 0);
            check_eq("stall_busy",       busy0, 1);
        end
        check_eq("stall_next_en", next_en0, 1);

        // enable low: consumer still drains, producer does not restart
        enable = 1'b0;
        layer_next_done = 1'b1;
        step();
        layer_next_done = 1'b0;
        check_eq("dis_frames2", frames0, 2);
        step();
        check_eq("dis_next_rst",   next_rst0, 1);
        check_eq("dis_former_rst", former_rst0, 0);
        step();
        check_eq("dis_next_en", next_en0, 1);
        layer_next_done = 1'b1;
        step();
        layer_next_done = 1'b0;
        check_eq("dis_frames3", frames0, 3);
        step(); step();
        check_eq("empty_next_rst",   next_rst0, 0);
        check_eq("empty_next_en",    next_en0, 0);
        check_eq("empty_former_rst", former_rst0, 0);
        check_eq("empty_busy",       busy0, 0);
        check_eq("empty_err",        err0, 0);

        // stray consumer done while idle
        layer_next_done = 1'b1;
        step();
        layer_next_done = 1'b0;
        check_eq("stray_err",    err0, 1);
        check_eq("stray_frames", frames0, 3);
        step();
        check_eq("stray_err_sticky", err0, 1);

        // reset in the middle of a producer pass
        enable = 1'b1;
        step();
        check_eq("mid_start", former_rst0, 1);
        step();
        check_eq("mid_run", former_en0, 1);
        step();
        reset = 1'b0;
        #1;
        check_eq("arst_former_en", former_en0, 0);
        check_eq("arst_former_rst", former_rst0, 0);
        check_eq("arst_addr_a",    bank_addr_a0, 0);
        check_eq("arst_wren_a",    bank_wren_a0, 0);
        check_eq("arst_busy",      busy0, 0);
        check_eq("arst_err",       err0, 0);
        check_eq("arst_frames",    frames0, 0);
        enable = 1'b0;
        step();
        reset = 1'b1;
        step();
        check_eq("post_rst_frames", frames0, 0);
        check_eq("post_rst_busy",   busy0, 0);

        // serialized single-bank mode, three frames
        enable = 1'b1;
        mon_on = 1'b1;
        for (int f = 0; f < 3; f++) begin
            wait_en1(1'b0, ok);
            check_eq("s1_producer_start", ok, 1);
            step();
            layer_former_done = 1'b1;
            step();
            layer_former_done = 1'b0;
            wait_en1(1'b1, ok);
            check_eq("s1_consumer_start", ok, 1);
            check_eq("s1_q_a", q_a1, 16'h5555);
            step();
            layer_next_done = 1'b1;
            step();
            layer_next_done = 1'b0;
        end
        enable = 1'b0;
        step();
        mon_on = 1'b0;
        check_eq("s1_frames",       frames1, 3);
        check_eq("s1_overlap",      overlap_cnt, 0);
        check_eq("s1_drain_wren",   drain_wr_cnt, 0);
        check_eq("s1_err",          err1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
